uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm.sv | 126 ++++++++++++
 tb/tb_uart_rx_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive control FSM that sequences start/data/parity/stop sampling strobes
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       uart_rx_fsm_clk,
    input  logic       uart_rx_fsm_rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       dat_samp_en,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic [1:0] frame_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e     state_q, state_d;
    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [5:0] prescale_q, prescale_d;
    logic       par_en_q, par_en_d;
    logic       par_flag_q, par_flag_d;
    logic [1:0] frame_err_q, frame_err_d;
    logic [5:0] chk;
    logic       at_chk, at_eval, wrap;

    assign edge_cnt  = edge_cnt_q;
    assign bit_cnt   = bit_cnt_q;
    assign frame_err = frame_err_q;

    // State and frame-context registers; reset aborts any frame in progress
    always_ff @(posedge uart_rx_fsm_clk or negedge uart_rx_fsm_rst) begin
        if (!uart_rx_fsm_rst) begin
            state_q     <= IDLE;
            edge_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            prescale_q  <= 6'd8;
            par_en_q    <= 1'b0;
            par_flag_q  <= 1'b0;
            frame_err_q <= '0;
        end else begin
            state_q     <= state_d;
            edge_cnt_q  <= edge_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            prescale_q  <= prescale_d;
            par_en_q    <= par_en_d;
            par_flag_q  <= par_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next state, bit/edge counting and the per-state strobes; checks land at the bit midpoint
    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        prescale_d  = prescale_q;
        par_en_d    = par_en_q;
        par_flag_d  = par_flag_q;
        frame_err_d = frame_err_q;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
        chk         = {1'b0, prescale_q[5:1]} + 6'd2;
        at_chk      = edge_cnt_q == chk;
        at_eval     = edge_cnt_q == chk + 6'd1;
        wrap        = edge_cnt_q == prescale_q - 6'd1;
        dat_samp_en = state_q != IDLE;
        if (state_q != IDLE) begin
            edge_cnt_d = wrap ? 6'd0 : edge_cnt_q + 6'd1;
            bit_cnt_d  = wrap ? bit_cnt_q + 4'd1 : bit_cnt_q;
        end
        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!RX_IN) begin
                    state_d    = START;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                strt_chk_en = at_chk;
                if (at_eval && strt_glitch) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                deser_en = at_chk;
                if (wrap && bit_cnt_q == 4'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                par_chk_en = at_chk;
                if (at_eval) par_flag_d = par_err;
                if (wrap) state_d = STOP;
            end
            STOP: begin
                stp_chk_en = at_chk;
                if (at_eval) begin
                    frame_err_d = {par_flag_q, stp_err};
                    data_valid  = !par_flag_q && !stp_err;
                    state_d     = IDLE;
                    edge_cnt_d  = '0;
                    bit_cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: table-driven frame scenarios with a scoreboard of expected strobe events
module tb_uart_rx_fsm;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch, par_err, stp_err;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;
    logic [1:0] frame_err;
    logic [17:0] outs;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        int         pre;
        bit         par;
        bit         glitch;
        bit         perr;
        bit         serr;
        bit         b2b;
        int         dv_cyc;
        int         idle_cyc;
        logic [1:0] ferr;
    } vec_t;

    typedef struct {
        int cyc;
        int code;
        int ec;
        int bc;
    } ev_t;

    vec_t vecs[13];
    ev_t  q[$];

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .uart_rx_fsm_clk(clk),
        .uart_rx_fsm_rst(rst_n),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .Prescale(Prescale),
        .strt_glitch(strt_glitch),
        .par_err(par_err),
        .stp_err(stp_err),
        .dat_samp_en(dat_samp_en),
        .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt),
        .strt_chk_en(strt_chk_en),
        .deser_en(deser_en),
        .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en),
        .data_valid(data_valid),
        .frame_err(frame_err)
    );

    assign outs = {dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en, par_chk_en,
                   stp_chk_en, data_valid, frame_err};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered and left at a negedge; cycle 0 is the first START cycle
    task automatic run_frame(input vec_t v);
        int  chk, sb, nstb, code;
        bit  done, g_nxt, p_nxt, s_nxt;
        ev_t e;
        q.delete();
        chk = v.pre / 2 + 2;
        q.push_back('{chk, 1, chk, 0});
        if (!v.glitch) begin
            for (int k = 1; k <= DW; k++) q.push_back('{k * v.pre + chk, 2, chk, k});
            sb = v.par ? DW + 2 : DW + 1;
            if (v.par) q.push_back('{(DW + 1) * v.pre + chk, 3, chk, DW + 1});
            q.push_back('{sb * v.pre + chk, 4, chk, sb});
            if (v.dv_cyc >= 0) q.push_back('{v.dv_cyc, 5, chk + 1, sb});
        end
        Prescale = 6'(v.pre);
        PAR_EN   = v.par;
        RX_IN    = 1'b0;
        done  = 1'b0;
        g_nxt = 1'b0;
        p_nxt = 1'b0;
        s_nxt = 1'b0;
        for (int cyc = 0; cyc < 40 * v.pre + 20 && !done; cyc++) begin
            @(posedge clk);
            #1;
            RX_IN       = 1'b1;
            strt_glitch = g_nxt;
            par_err     = p_nxt;
            stp_err     = s_nxt;
            if (cyc == 2) begin
                Prescale = (v.pre == 8) ? 6'd32 : 6'd8;
                PAR_EN   = !v.par;
            end
            @(negedge clk);
            if (cyc == 0) begin
                check("start_edge_cnt", int'(edge_cnt), 0);
                check("start_bit_cnt", int'(bit_cnt), 0);
                check("start_busy", int'(dat_samp_en), 1);
            end
            nstb = int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) + int'(stp_chk_en) + int'(data_valid);
            if (nstb > 1) check("strobe_overlap", nstb, 1);
            if (nstb == 1) begin
                code = strt_chk_en ? 1 : deser_en ? 2 : par_chk_en ? 3 : stp_chk_en ? 4 : 5;
                if (q.size() == 0) check("unexpected_strobe", code, 0);
                else begin
                    e = q.pop_front();
                    check("strobe_kind", code, e.code);
                    check("strobe_cycle", cyc, e.cyc);
                    check("strobe_edge_cnt", int'(edge_cnt), e.ec);
                    check("strobe_bit_cnt", int'(bit_cnt), e.bc);
                end
            end
            g_nxt = strt_chk_en ? v.glitch : 1'b0;
            p_nxt = par_chk_en ? v.perr : 1'b0;
            s_nxt = stp_chk_en ? v.serr : 1'b0;
            if (!dat_samp_en) begin
                done = 1'b1;
                check("idle_cycle", cyc, v.idle_cyc);
                check("idle_counters", int'({edge_cnt, bit_cnt}), 0);
            end
        end
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        check("frame_done", int'(done), 1);
        check("missing_events", q.size(), 0);
        check("frame_err", int'(frame_err), int'(v.ferr));
    endtask

    initial begin
        bit dv_seen;
        //         pre par gl  pe  se  b2b dv   idle ferr
        vecs[0]  = '{8,  1, 0, 0, 0, 0,  87,  88, 2'b00};
        vecs[1]  = '{8,  0, 0, 0, 0, 0,  79,  80, 2'b00};
        vecs[2]  = '{16, 1, 0, 0, 0, 0,  171, 172, 2'b00};
        vecs[3]  = '{8,  1, 0, 1, 1, 0,  -1,  88, 2'b11};
        vecs[4]  = '{8,  1, 1, 0, 0, 0,  -1,  8,  2'b11};
        vecs[5]  = '{8,  1, 0, 0, 0, 0,  87,  88, 2'b00};
        vecs[6]  = '{32, 0, 0, 0, 0, 0,  307, 308, 2'b00};
        vecs[7]  = '{16, 0, 0, 0, 1, 0,  -1,  156, 2'b01};
        vecs[8]  = '{16, 1, 0, 1, 0, 1,  -1,  172, 2'b10};
        vecs[9]  = '{8,  0, 0, 1, 0, 0,  79,  80, 2'b00};
        vecs[10] = '{32, 1, 1, 0, 0, 0,  -1,  20, 2'b00};
        vecs[11] = '{8,  1, 0, 1, 1, 1,  -1,  88, 2'b11};
        vecs[12] = '{8,  1, 0, 0, 0, 0,  87,  88, 2'b00};

        rst_n       = 1'b0;
        RX_IN       = 1'b0;
        PAR_EN      = 1'b1;
        Prescale    = 6'd8;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", int'(outs), 0);
        end
        RX_IN = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", int'(outs), 0);

        for (int i = 0; i < 12; i++) begin
            run_frame(vecs[i]);
            if (!vecs[i].b2b) begin
                repeat (2) @(negedge clk);
                check("idle_gap", int'(dat_samp_en), 0);
            end
        end

        // Second back-to-back frame, aborted by reset mid-DATA
        dv_seen  = 1'b0;
        Prescale = 6'd8;
        PAR_EN   = 1'b1;
        RX_IN    = 1'b0;
        @(posedge clk);
        #1 RX_IN = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (data_valid) dv_seen = 1'b1;
        end
        check("abort_busy", int'(dat_samp_en), 1);
        check("abort_pos", int'({bit_cnt, edge_cnt}), int'({4'd3, 6'd5}));
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", int'(outs), 0);
        repeat (2) begin
            @(negedge clk);
            if (data_valid) dv_seen = 1'b1;
            check("rst_hold_outputs", int'(outs), 0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (data_valid) dv_seen = 1'b1;
            check("post_abort_idle", int'(dat_samp_en), 0);
        end
        check("no_dv_aborted", int'(dv_seen), 0);

        run_frame(vecs[12]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
